// File: rtl/bridge_gate_driver_pkg.sv
// Shared types and constants for the full-bridge gate driver: FSM encoding,
// fault-cause codes and the leg-to-gate-pin mapping.
package bridge_gate_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_EXT  = 2'b01;
   localparam logic [1:0] FC_FREQ = 2'b10;

   localparam int MIN_HALF_DEFAULT = 20;

   // Q1 = leg A, Q2 = leg B; diagonal switch pairs share a leg.
   function automatic logic [7:0] map_gates(input logic q1, input logic q2);
      return {q1, q2, q2, q1, q1, q2, q2, q1};
   endfunction

endpackage

// File: rtl/bridge_deadtime_leg.sv
// One bridge leg: the gate follows its command only after the command has
// been high for at least deadtime_i cycles.
module bridge_deadtime_leg #(
   parameter int DT_WIDTH = 10
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cmd_i,
   input  logic [DT_WIDTH-1:0] deadtime_i,
   output logic                gate_o
);

   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic                gate_q, gate_d;

   always_comb begin
      cnt_d = '0;
      if (cmd_i) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      gate_d = cmd_i && (cnt_q >= deadtime_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         gate_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gate_q <= gate_d;
      end
   end

   assign gate_o = gate_q;

endmodule

// File: rtl/bridge_gate_driver.sv
// Full-bridge output stage: dead-time gate generation, enable sequencing,
// latched fault trip and sigma period measurement.
module bridge_gate_driver
   import bridge_gate_driver_pkg::*;
#(
   parameter int DT_WIDTH     = 10,
   parameter int PERIOD_WIDTH = 16,
   parameter int MIN_HALF     = MIN_HALF_DEFAULT
) (
   input  logic                    i_clock,
   input  logic                    i_RESET,
   input  logic                    i_sigma,
   input  logic                    i_enable,
   input  logic                    i_fault,
   input  logic                    i_clear_fault,
   input  logic [DT_WIDTH-1:0]     i_deadtime,
   output logic [7:0]              o_Q,
   output logic                    o_running,
   output logic                    o_fault,
   output logic [1:0]              o_fault_cause,
   output logic [PERIOD_WIDTH-1:0] o_period,
   output logic                    o_period_valid
);

   localparam logic [PERIOD_WIDTH:0] MIN_HALF_W = (PERIOD_WIDTH+1)'(MIN_HALF);

   state_e                  state_q, state_d;
   logic                    sigma_r_q, sigma_rr_q;
   logic                    fault_q, fault_d;
   logic [1:0]              cause_q, cause_d;
   logic                    running_q;
   logic [PERIOD_WIDTH-1:0] half_q, half_d;
   logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    period_vld_q;
   logic [7:0]              q_q, q_d;
   logic                    sig_edge, sig_rise, short_half;
   logic [PERIOD_WIDTH:0]   half_len;
   logic                    gate_a, gate_b;

   assign sig_edge   = sigma_r_q != sigma_rr_q;
   assign sig_rise   = sigma_r_q && !sigma_rr_q;
   // Counter holds cycles-since-edge minus one; compare the true half-period length.
   assign half_len   = {1'b0, half_q} + 1'b1;
   assign short_half = half_len < MIN_HALF_W;

   bridge_deadtime_leg #(.DT_WIDTH(DT_WIDTH)) u_leg_a (
      .clk_i      (i_clock),
      .rst_ni     (i_RESET),
      .cmd_i      (~sigma_r_q),
      .deadtime_i (i_deadtime),
      .gate_o     (gate_a)
   );

   bridge_deadtime_leg #(.DT_WIDTH(DT_WIDTH)) u_leg_b (
      .clk_i      (i_clock),
      .rst_ni     (i_RESET),
      .cmd_i      (sigma_r_q),
      .deadtime_i (i_deadtime),
      .gate_o     (gate_b)
   );

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_fault) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = FC_EXT;
            end else if (i_enable) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            if (i_fault) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = FC_EXT;
            end else if (!i_enable) begin
               state_d = ST_IDLE;
            end else if (sig_edge) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_fault) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = FC_EXT;
            end else if (sig_edge && short_half) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = FC_FREQ;
            end else if (!i_enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (i_clear_fault && !i_fault && !i_enable) begin
               state_d = ST_IDLE;
               fault_d = 1'b0;
               cause_d = FC_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      half_d    = sig_edge ? '0 : ((half_q == '1) ? half_q : half_q + 1'b1);
      per_cnt_d = sig_rise ? '0 : ((per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1);
      period_d  = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;
      // Gating on the registered state blanks the gates one edge after leaving RUN.
      q_d       = (state_q == ST_RUN) ? map_gates(gate_a, gate_b) : 8'h00;
   end

   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         state_q      <= ST_IDLE;
         sigma_r_q    <= 1'b0;
         sigma_rr_q   <= 1'b0;
         fault_q      <= 1'b0;
         cause_q      <= FC_NONE;
         running_q    <= 1'b0;
         half_q       <= '0;
         per_cnt_q    <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         q_q          <= 8'h00;
      end else begin
         state_q      <= state_d;
         sigma_r_q    <= i_sigma;
         sigma_rr_q   <= sigma_r_q;
         fault_q      <= fault_d;
         cause_q      <= cause_d;
         running_q    <= (state_d == ST_RUN);
         half_q       <= half_d;
         per_cnt_q    <= per_cnt_d;
         period_vld_q <= sig_rise;
         q_q          <= q_d;
         if (sig_rise) begin
            period_q <= period_d;
         end
      end
   end

   assign o_Q            = q_q;
   assign o_running      = running_q;
   assign o_fault        = fault_q;
   assign o_fault_cause  = cause_q;
   assign o_period       = period_q;
   assign o_period_valid = period_vld_q;

endmodule

// File: tb/tb_bridge_gate_driver.sv
// Scoreboard bench for bridge_gate_driver: stimulus queues expected gate
// transitions and period reports; negedge monitors pop and compare.
module tb_bridge_gate_driver;

   logic        clk = 1'b0;
   logic        i_RESET = 1'b0;
   logic        i_sigma = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_fault = 1'b0;
   logic        i_clear_fault = 1'b0;
   logic [9:0]  i_deadtime = 10'd5;
   logic [7:0]  o_Q;
   logic        o_running;
   logic        o_fault;
   logic [1:0]  o_fault_cause;
   logic [15:0] o_period;
   logic        o_period_valid;

   bridge_gate_driver #(.DT_WIDTH(10), .PERIOD_WIDTH(16), .MIN_HALF(20)) dut (
      .i_clock        (clk),
      .i_RESET        (i_RESET),
      .i_sigma        (i_sigma),
      .i_enable       (i_enable),
      .i_fault        (i_fault),
      .i_clear_fault  (i_clear_fault),
      .i_deadtime     (i_deadtime),
      .o_Q            (o_Q),
      .o_running      (o_running),
      .o_fault        (o_fault),
      .o_fault_cause  (o_fault_cause),
      .o_period       (o_period),
      .o_period_valid (o_period_valid)
   );

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } gev_t;

   gev_t       gq[$];
   int         pq[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   bit         gate_en = 1'b0;
   bit         per_en = 1'b0;
   logic [7:0] prev_q = 8'h00;
   logic [7:0] exp_q = 8'h00;
   int         mode = 0;       // 0 idle/fault, 1 armed, 2 running, 3 fault
   int         last_c = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_gate(input logic [7:0] val, input int c);
      gev_t e;
      e.val = val;
      e.cyc = c;
      gq.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Toggle sigma one edge later; the next toggle lands exactly `half` edges after this one.
   task automatic toggle(input int half, input int per_val);
      int         c;
      int         dt;
      logic [7:0] pat;
      @(posedge clk);
      #1;
      i_sigma = ~i_sigma;
      c   = cyc;
      dt  = int'(i_deadtime);
      pat = i_sigma ? 8'h66 : 8'h99;
      if (mode == 2 && (c - last_c) < 20) begin
         if (exp_q != 8'h00) push_gate(8'h00, c + 3);
         exp_q = 8'h00;
         mode  = 3;
      end else if (mode == 1 || mode == 2) begin
         if (exp_q != 8'h00 && dt != 0) push_gate(8'h00, c + 3);
         push_gate(pat, c + 3 + dt);
         exp_q = pat;
         mode  = 2;
      end
      if (per_val >= 0 && i_sigma) pq.push_back(per_val);
      last_c = c;
      wait_cyc(half - 1);
   endtask

   always @(negedge clk) begin : monitor
      gev_t e;
      int   pv;
      if (gate_en && o_Q !== prev_q) begin
         if (gq.size() == 0) begin
            check("gate_unexpected_change_qsize", gq.size(), 1);
         end else begin
            e = gq.pop_front();
            check("gate_value", o_Q, e.val);
            check("gate_cycle", cyc, e.cyc);
         end
      end
      prev_q = o_Q;
      if (per_en && o_period_valid) begin
         if (pq.size() == 0) begin
            check("period_unexpected_qsize", pq.size(), 1);
         end else begin
            pv = pq.pop_front();
            check("period_value", o_period, pv);
         end
      end
   end

   initial begin
      int c;
      // Reset values
      #20;
      check("rst_Q", o_Q, 0);
      check("rst_running", o_running, 0);
      check("rst_fault", o_fault, 0);
      check("rst_cause", o_fault_cause, 0);
      check("rst_period", o_period, 0);
      check("rst_period_valid", o_period_valid, 0);
      @(posedge clk);
      #3 i_RESET = 1'b1;
      wait_cyc(5);
      gate_en = 1'b1;

      // Enable, dead time 5, half-period 100
      i_deadtime = 10'd5;
      i_enable   = 1'b1;
      mode       = 1;
      wait_cyc(30);
      check("arm_running", o_running, 0);
      check("arm_Q", o_Q, 0);
      for (int i = 0; i < 4; i++) toggle(100, -1);
      check("run_running", o_running, 1);
      c = cyc;
      i_enable = 1'b0;
      if (exp_q != 8'h00) push_gate(8'h00, c + 2);
      exp_q = 8'h00;
      mode  = 0;
      wait_cyc(5);
      check("disable_running", o_running, 0);

      // Dead-time latency for 0, 10 and 1023
      i_deadtime = 10'd0;
      i_enable   = 1'b1;
      mode       = 1;
      wait_cyc(3);
      toggle(2000, -1);
      toggle(2000, -1);
      i_deadtime = 10'd10;
      toggle(2000, -1);
      toggle(2000, -1);
      i_deadtime = 10'd1023;
      toggle(2000, -1);
      toggle(2000, -1);
      i_deadtime = 10'd5;

      // Over-frequency: 20 is legal, 19 trips
      toggle(20, -1);
      toggle(19, -1);
      check("half20_no_fault", o_fault, 0);
      check("half20_running", o_running, 1);
      toggle(5, -1);
      check("freq_fault", o_fault, 1);
      check("freq_cause", o_fault_cause, 2);
      check("freq_running", o_running, 0);
      check("freq_Q", o_Q, 0);
      i_enable      = 1'b0;
      i_clear_fault = 1'b1;
      wait_cyc(3);
      i_clear_fault = 1'b0;
      mode = 0;
      check("freq_clear_fault", o_fault, 0);
      check("freq_clear_cause", o_fault_cause, 0);

      // External fault wins over disable in the same cycle
      i_enable = 1'b1;
      mode     = 1;
      wait_cyc(2);
      toggle(200, -1);
      check("ext_pre_running", o_running, 1);
      c = cyc;
      i_fault  = 1'b1;
      i_enable = 1'b0;
      if (exp_q != 8'h00) push_gate(8'h00, c + 2);
      exp_q = 8'h00;
      mode  = 3;
      wait_cyc(3);
      check("ext_fault", o_fault, 1);
      check("ext_cause", o_fault_cause, 1);
      check("ext_running", o_running, 0);
      i_fault       = 1'b0;
      i_enable      = 1'b1;
      i_clear_fault = 1'b1;
      wait_cyc(5);
      check("ext_clear_enabled_fault", o_fault, 1);
      check("ext_clear_enabled_cause", o_fault_cause, 1);
      i_enable = 1'b0;
      wait_cyc(3);
      check("ext_cleared_fault", o_fault, 0);
      check("ext_cleared_cause", o_fault_cause, 0);
      i_clear_fault = 1'b0;
      mode = 0;

      // Period measurement, including saturation after a long constant sigma
      if (i_sigma) toggle(250, -1);
      toggle(250, -1);
      per_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         toggle(250, -1);
         toggle(250, 500);
      end
      toggle(66000, -1);
      toggle(250, 65535);
      toggle(250, -1);
      toggle(250, 500);
      wait_cyc(3);
      per_en = 1'b0;

      // Asynchronous reset in the middle of a pulse
      i_enable = 1'b1;
      mode     = 1;
      toggle(300, -1);
      toggle(300, -1);
      check("pre_reset_running", o_running, 1);
      #3;
      gate_en = 1'b0;
      i_RESET = 1'b0;
      #1;
      check("async_rst_Q", o_Q, 0);
      check("async_rst_running", o_running, 0);
      check("async_rst_fault", o_fault, 0);
      check("async_rst_cause", o_fault_cause, 0);
      check("async_rst_period", o_period, 0);
      check("async_rst_period_valid", o_period_valid, 0);
      i_enable = 1'b0;
      #7 i_RESET = 1'b1;
      mode  = 0;
      exp_q = 8'h00;
      wait_cyc(10);
      check("post_rst_idle_running", o_running, 0);
      check("post_rst_idle_Q", o_Q, 0);
      gate_en  = 1'b1;
      i_enable = 1'b1;
      mode     = 1;
      wait_cyc(5);
      check("post_rst_arm_running", o_running, 0);
      toggle(100, -1);
      toggle(100, -1);
      check("post_rst_run_running", o_running, 1);

      wait_cyc(20);
      check("gate_queue_empty", gq.size(), 0);
      check("period_queue_empty", pq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bridge_gate_driver.md
Name: bridge_gate_driver

Overview:
Output stage between the hybrid control law and the full-bridge gate pins. It consumes the switching state sigma from the hybrid controller and produces the eight gate signals with per-leg dead time. It also provides enable sequencing, a latched fault trip from ADC out-of-range or over-frequency, and a switching-period measurement for debug display. It replaces the loose dead-time instances and Q gating at the top level.

Parameters:
DT_WIDTH, 10, width of the dead-time input in clock cycles
PERIOD_WIDTH, 16, width of the period counter and output
MIN_HALF, 20, minimum legal sigma half-period in cycles; a shorter half-period trips an over-frequency fault

Ports:
i_clock  in  1  main clock (clk_100M)
i_RESET  in  1  asynchronous reset, active-low
i_sigma  in  1  switching state from the hybrid controller, synchronous to i_clock
i_enable  in  1  converter enable, level
i_fault  in  1  external fault, level (ADA_OR | ADB_OR)
i_clear_fault  in  1  fault acknowledge, level (debounced button)
i_deadtime  in  DT_WIDTH  dead time in cycles
o_Q  out  8  gate drives
o_running  out  1  high in the RUN state
o_fault  out  1  latched fault indicator
o_fault_cause  out  2  01 = external, 10 = over-frequency, 00 = none
o_period  out  PERIOD_WIDTH  last measured sigma period in cycles
o_period_valid  out  1  one-cycle strobe when o_period updates

Behaviour:
- Reset, asynchronous and active-low:
  - All registers clear.
  - o_Q = 0, o_running = 0, o_fault = 0, o_fault_cause = 0, o_period = 0, o_period_valid = 0.
  - State = IDLE.
- Input register:
  - sigma_r <= i_sigma every cycle.
  - An edge is sigma_r != sigma_rr.
- State machine: IDLE, ARM, RUN, FAULT.
  - IDLE -> ARM when i_enable=1 and i_fault=0.
  - ARM -> RUN on the first sigma edge, so the first pulse is full length. ARM -> IDLE if i_enable drops.
  - RUN -> IDLE when i_enable=0.
  - From any non-FAULT state -> FAULT when i_fault=1, with cause 01. This has priority over the enable transitions.
  - RUN -> FAULT, with cause 10, on a sigma edge whose half-period count < MIN_HALF.
  - If both fault causes occur in the same cycle, external wins and cause = 01.
  - FAULT -> IDLE only when i_clear_fault=1, i_fault=0 and i_enable=0. o_fault and o_fault_cause clear on that transition. If any condition fails, stay in FAULT.
- Dead time, per leg:
  - Leg A command = ~sigma_r; leg B command = sigma_r.
  - Each leg has a counter that resets to 0 when its command is low and increments, saturating, while its command is high.
  - The leg output is high when command=1, counter >= i_deadtime, and state == RUN.
  - Outputs are registered.
- Latency: with i_sigma changing before clock edge k:
  - The leg turning off goes low at edge k+2.
  - The leg turning on goes high at edge k+2+i_deadtime.
  - i_deadtime=0 gives simultaneous switching. This is legal and not guarded.
  - Changes to i_deadtime apply immediately to the comparison.
- Shutdown: leaving RUN (disable or fault) forces o_Q = 0 at the next edge, regardless of the dead-time counters.
- Output mapping, with Q1 = leg A and Q2 = leg B: o_Q[0]=Q1, [1]=Q2, [2]=Q2, [3]=Q1, [4]=Q1, [5]=Q2, [6]=Q2, [7]=Q1.
- Half-period counter:
  - Clears on every sigma edge, increments otherwise, saturating at all-ones.
  - The over-frequency check is evaluated only in RUN, against the value before clearing.
- Period measurement:
  - A counter clears on each rising edge of sigma_r and saturates at 2^PERIOD_WIDTH-1.
  - On each rising edge, in any state, o_period <= count+1 and o_period_valid pulses for one cycle.
  - The first rising edge after reset also reports.
- o_running = (state == RUN), registered.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, ARM=1, RUN=2, FAULT=3
  - fault-cause constants: FC_NONE, FC_EXT, FC_FREQ
  - default MIN_HALF
- One natural sub-module, bridge_deadtime_leg: one command, counter and comparator, instantiated twice. It supersedes the per-leg dead_time instances.

Test Plan:
1. Reset/enable:
   - Stimulus: hold i_RESET=0, then release; i_enable=1; sigma toggling every 100 cycles; i_deadtime=5.
   - Required: o_Q=0 until the first sigma edge. Then o_Q=8'h99 (leg A) or 8'h66 (leg B) patterns with a 5-cycle gap in which both legs are low. o_running=1.
2. Dead-time latency:
   - Stimulus: i_deadtime=0, then 10, then 1023, with a half-period of 2000 cycles.
   - Required: off-leg falls at k+2 and on-leg rises at k+2+DT for each value; DT=1023 still yields pulses.
3. Over-frequency:
   - Stimulus: in RUN with MIN_HALF=20, toggle sigma after 19 cycles.
   - Required: FAULT, o_fault_cause=2'b10, o_Q=0 at the next edge.
   - A toggle after exactly 20 cycles causes no trip.
4. External fault priority:
   - Stimulus: assert i_fault in the same cycle as i_enable falls.
   - Required: FAULT with cause 01.
   - i_clear_fault with i_enable=1 leaves the state in FAULT; with i_enable=0 and i_fault=0 the state goes to IDLE and cause clears.
5. Period measurement:
   - Stimulus: sigma period 500 cycles, then a constant sigma for 70000 cycles, then toggling again.
   - Required: o_period=500 with valid pulses during the 500-cycle toggling. After toggling resumes, the first report is 65535 (saturated).
6. Reset mid-operation:
   - Stimulus: assert i_RESET in RUN mid-pulse, asynchronously between edges.
   - Required: o_Q=0 immediately and all outputs at reset values. After release, the block stays in IDLE until i_enable is seen, then goes to ARM.
